// File: rtl/io_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : io_buffer_pkg
//  Description : Shared definitions for the IO data buffer slice: buffer FSM
//                state encoding, default data width / FIFO depth and the
//                pointer-width helper used to size FIFO pointers and counts.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package io_buffer_pkg;

    localparam int c_DEFAULT_WIDTH = 8;
    localparam int c_DEFAULT_DEPTH = 4;

    // Transaction FSM states; CMD is only reachable when command capture is built in.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WRITE = 2'd2,
        ST_READ  = 2'd3
    } bufferState_t;

    // Bits needed to address DEPTH entries (DEPTH is a power of two, >= 2).
    function automatic int ptrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_data_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : io_data_buffer_if
//  Description : Control/status bundle of the IO data buffer. The two data
//                buses are bidirectional and stay plain inout ports on the
//                buffer itself; everything else travels through this bundle.
//  Signals     : readEnable, ioStrobe, memReady, stop      (master -> buffer)
//                memStrobe, dataControl, controlValid,
//                fifoCount, fifoFull, fifoEmpty, overflow  (buffer -> master)
//  Modports    : master (bus master / memory side), slave (io_data_buffer)
//  Revision    : 1.0 - initial release
// ============================================================================
interface io_data_buffer_if #(
    parameter int WIDTH = io_buffer_pkg::c_DEFAULT_WIDTH,
    parameter int DEPTH = io_buffer_pkg::c_DEFAULT_DEPTH
);
    import io_buffer_pkg::*;

    logic                     readEnable;
    logic                     ioStrobe;
    logic                     memReady;
    logic                     stop;
    logic                     memStrobe;
    logic [WIDTH-1:0]         dataControl;
    logic                     controlValid;
    logic [ptrWidth(DEPTH):0] fifoCount;
    logic                     fifoFull;
    logic                     fifoEmpty;
    logic                     overflow;

    modport master (
        output readEnable, ioStrobe, memReady, stop,
        input  memStrobe, dataControl, controlValid,
        input  fifoCount, fifoFull, fifoEmpty, overflow
    );

    modport slave (
        input  readEnable, ioStrobe, memReady, stop,
        output memStrobe, dataControl, controlValid,
        output fifoCount, fifoFull, fifoEmpty, overflow
    );

endinterface
`default_nettype wire

// File: rtl/buffer_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : buffer_fifo
//  Description : Single-clock synchronous FIFO with exact occupancy count.
//                A push while full is accepted only when a pop happens in
//                the same cycle. Flush empties the FIFO on the next edge and
//                overrides push/pop.
//  Ports       : clk, rst (async, active high)
//                i_push, i_pop, i_flush  - requests
//                i_data / o_data         - write data / head of queue
//                o_count, o_full, o_empty - occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module buffer_fifo
    import io_buffer_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH,
    parameter int DEPTH = c_DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic [ptrWidth(DEPTH):0] o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int                 c_PTR_W      = ptrWidth(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL_COUNT = (c_PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wrPtr;
    logic [c_PTR_W-1:0] r_rdPtr;
    logic [c_PTR_W:0]   r_count;
    logic               w_doPush;
    logic               w_doPop;

    assign o_full   = (r_count == c_FULL_COUNT);
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_data   = r_mem[r_rdPtr];

    assign w_doPop  = i_pop && !o_empty;
    // Full FIFO still takes a byte when the head leaves in the same cycle.
    assign w_doPush = i_push && (!o_full || w_doPop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_doPush && !i_flush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/io_data_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : io_data_buffer
//  Description : Bidirectional IO <-> memory data buffer. A rising edge of
//                readEnable opens a write transaction (IO bytes queued and
//                streamed to memory); readEnable low with memReady opens a
//                read transaction (memory words queued and handed to IO).
//                stop or a readEnable change aborts and flushes.
//  Config      : define IO_DATA_BUFFER_CMD_EN to capture the first IO byte of
//                a write transaction as a command (dataControl/controlValid);
//                without it every write byte is data and the command outputs
//                are tied low.
//  Ports       : clk        - clock, rising edge
//                reset      - asynchronous, active-high reset
//                dataIO     - inout, bus-master-side data
//                dataMemory - inout, memory-side data
//                bus        - io_data_buffer_if.slave control/status bundle
//  Revision    : 1.0 - initial release
// ============================================================================
module io_data_buffer
    import io_buffer_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH,
    parameter int DEPTH = c_DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    inout  wire  [WIDTH-1:0] dataIO,
    inout  wire  [WIDTH-1:0] dataMemory,
    io_data_buffer_if.slave  bus
);

    bufferState_t             r_state;
    bufferState_t             w_stateNext;
    logic                     r_readEnablePrev;
    logic                     r_overflow;
    logic                     w_readEnableRise;
    logic                     w_abort;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_flush;
    logic                     w_overflowSet;
    logic [WIDTH-1:0]         w_fifoIn;
    logic [WIDTH-1:0]         w_head;
    logic [ptrWidth(DEPTH):0] w_count;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_ioDrive;
    logic                     w_memDrive;
`ifdef IO_DATA_BUFFER_CMD_EN
    logic                     w_capture;
    logic                     r_controlValid;
    logic [WIDTH-1:0]         r_dataControl;
`endif

    assign w_readEnableRise = bus.readEnable && !r_readEnablePrev;
    assign w_abort          = bus.stop || (bus.readEnable != r_readEnablePrev);

    // ------------------------------------------------------------------
    // State register and edge-detect history. The history resets to 1 so
    // a readEnable held high through reset is not seen as a new edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_readEnablePrev <= 1'b1;
            r_overflow       <= 1'b0;
        end else begin
            r_state          <= w_stateNext;
            r_readEnablePrev <= bus.readEnable;
            if (w_flush) begin
                r_overflow <= 1'b0;
            end else if (w_overflowSet) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and FIFO requests
    // ------------------------------------------------------------------
    always_comb begin
        w_stateNext   = r_state;
        w_push        = 1'b0;
        w_pop         = 1'b0;
        w_flush       = 1'b0;
        w_overflowSet = 1'b0;
        w_fifoIn      = dataIO;
`ifdef IO_DATA_BUFFER_CMD_EN
        w_capture     = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (!bus.stop) begin
                    if (w_readEnableRise) begin
`ifdef IO_DATA_BUFFER_CMD_EN
                        w_stateNext = ST_CMD;
`else
                        w_stateNext = ST_WRITE;
`endif
                    end else if (!bus.readEnable && bus.memReady) begin
                        // The word presented in the opening cycle is kept.
                        w_stateNext = ST_READ;
                        w_push      = 1'b1;
                        w_fifoIn    = dataMemory;
                    end
                end
            end
`ifdef IO_DATA_BUFFER_CMD_EN
            ST_CMD: begin
                if (w_abort) begin
                    w_stateNext = ST_IDLE;
                    w_flush     = 1'b1;
                end else if (bus.ioStrobe) begin
                    w_capture   = 1'b1;
                    w_stateNext = ST_WRITE;
                end
            end
`endif
            ST_WRITE: begin
                if (w_abort) begin
                    w_stateNext = ST_IDLE;
                    w_flush     = 1'b1;
                end else begin
                    w_pop         = !w_empty && bus.memReady;
                    w_push        = bus.ioStrobe;
                    w_overflowSet = bus.ioStrobe && w_full && !w_pop;
                end
            end
            ST_READ: begin
                if (w_abort) begin
                    w_stateNext = ST_IDLE;
                    w_flush     = 1'b1;
                end else begin
                    w_push   = bus.memReady && !w_full;
                    w_pop    = bus.ioStrobe && !w_empty;
                    w_fifoIn = dataMemory;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    buffer_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  (w_fifoIn),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // ------------------------------------------------------------------
    // Command capture
    // ------------------------------------------------------------------
`ifdef IO_DATA_BUFFER_CMD_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_controlValid <= 1'b0;
            r_dataControl  <= '0;
        end else begin
            r_controlValid <= w_capture;
            if (w_capture) begin
                r_dataControl <= dataIO;
            end
        end
    end

    assign bus.controlValid = r_controlValid;
    assign bus.dataControl  = r_dataControl;
`else
    assign bus.controlValid = 1'b0;
    assign bus.dataControl  = '0;
`endif

    // ------------------------------------------------------------------
    // Bus drivers: each bus is owned by exactly one state, so they are
    // never driven together.
    // ------------------------------------------------------------------
    assign w_memDrive = (r_state == ST_WRITE) && !w_empty;
    assign w_ioDrive  = (r_state == ST_READ);

    assign dataMemory = w_memDrive ? w_head : 'z;
    assign dataIO     = w_ioDrive  ? w_head : 'z;

    assign bus.memStrobe = w_memDrive;
    assign bus.fifoCount = w_count;
    assign bus.fifoFull  = w_full;
    assign bus.fifoEmpty = w_empty;
    assign bus.overflow  = r_overflow;

endmodule
`default_nettype wire

// File: doc/io_data_buffer.md
IO_DATA_BUFFER -- requirements
Module: io_data_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data byte/word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: FIFO entries, a power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port dataIO, inout, WIDTH bits: bus-master-side data.
REQ-006 SHALL have port dataMemory, inout, WIDTH bits: memory-array-side data.
REQ-007 SHALL have port readEnable, input, 1 bit: 1 = write transaction (IO to memory), 0 = read transaction (memory to IO).
REQ-008 SHALL have port ioStrobe, input, 1 bit: one-cycle IO byte event; push in write, pop in read.
REQ-009 SHALL have port memReady, input, 1 bit: memory accepts (write) or presents (read) a word this cycle.
REQ-010 SHALL have port stop, input, 1 bit: transaction end.
REQ-011 SHALL have port memStrobe, output, 1 bit: a valid write word is on dataMemory.
REQ-012 SHALL have port dataControl, output, WIDTH bits: captured command byte.
REQ-013 SHALL have port controlValid, output, 1 bit: one-cycle pulse on command capture.
REQ-014 SHALL have port fifoCount, output, log2(DEPTH)+1 bits: occupancy.
REQ-015 SHALL have ports fifoFull and fifoEmpty, output, 1 bit each: occupancy flags.
REQ-016 SHALL have port overflow, output, 1 bit: sticky flag for a dropped byte.

Function
REQ-017 SHALL implement an FSM with states IDLE, CMD, WRITE and READ.
REQ-018 SHALL move IDLE->CMD on a rising edge of readEnable, and IDLE->READ when readEnable is 0 and memReady is 1.
REQ-019 SHALL, in CMD on ioStrobe, register dataIO into dataControl, pulse controlValid the next cycle, and move to WRITE; the command byte is never pushed.
REQ-020 SHALL, in WRITE, push dataIO on ioStrobe when not full; if full and no pop occurs that cycle, drop the byte and set overflow.
REQ-021 SHALL, in WRITE, drive memStrobe = !fifoEmpty combinationally and drive dataMemory with the FIFO head whenever !fifoEmpty, else Z.
REQ-022 SHALL, in WRITE, pop the FIFO on a clock edge where memStrobe and memReady are both 1.
REQ-023 SHALL, in WRITE when full, accept a same-cycle push and pop: count unchanged, no overflow.
REQ-024 SHALL, in READ, push dataMemory on memReady when not full; if full, ignore memReady (no overflow).
REQ-025 SHALL, in READ, drive dataIO with the FIFO head, and pop on ioStrobe when not empty; ioStrobe while empty has no effect.
REQ-026 SHALL drive dataIO to Z outside READ and dataMemory to Z outside WRITE; the two buses are never driven simultaneously.
REQ-027 SHALL, on stop or a readEnable change, go to IDLE, flush the FIFO (count 0) and clear overflow the next cycle; stop takes priority over same-cycle strobes, which are discarded.
REQ-028 SHALL hold dataControl until the next capture or reset.
REQ-029 SHALL wrap read and write pointers modulo DEPTH, with fifoCount exact from 0 to DEPTH.

Reset
REQ-030 SHALL, on reset, asynchronously set state IDLE, pointers 0, fifoCount 0, fifoEmpty 1, fifoFull 0, overflow 0, controlValid 0, dataControl 0, memStrobe 0, and both buses Z.
REQ-031 SHALL, when reset asserts mid-transaction, lose FIFO contents and resume only after a fresh readEnable edge.

Configuration
REQ-032 SHALL, with IO_DATA_BUFFER_CMD_EN defined, implement the CMD state and command capture as specified above.
REQ-033 SHALL, without IO_DATA_BUFFER_CMD_EN, omit CMD: IDLE->WRITE directly, every write byte pushed, dataControl tied 0, controlValid tied 0.

Structure
REQ-034 SHALL place the state enum, default WIDTH/DEPTH constants and the pointer-width function in shared package io_buffer_pkg.
REQ-035 SHALL implement storage in sub-module buffer_fifo (synchronous, single-clock, push/pop/count/full/empty), instantiated once.

Verification
REQ-036 SHALL cover CMD_EN write: readEnable 0->1, ioStrobe with 0xA0, 0x11, 0x22 -> dataControl=0xA0, controlValid 1-cycle pulse, fifoCount=2, memReady drains 0x11 then 0x22, fifoEmpty=1.
REQ-037 SHALL cover DEPTH=4 overflow: 5 data bytes with memReady=0 -> fifoFull=1, fifoCount=4, overflow=1, 5th byte absent from drain.
REQ-038 SHALL cover full simultaneity: full FIFO, ioStrobe and memReady same cycle -> count stays 4, overflow=0, FIFO order preserved.
REQ-039 SHALL cover read: readEnable=0, memReady with 0x5A, 0x3C -> dataIO=0x5A, ioStrobe -> dataIO=0x3C, ioStrobe -> fifoEmpty=1; dataMemory never driven.
REQ-040 SHALL cover abort: stop mid-write with fifoCount=3 -> IDLE, fifoCount=0, overflow=0, buses Z next cycle.
REQ-041 SHALL cover async reset: reset asserted between edges mid-read -> outputs at REQ-030 values immediately, before the next clk edge.
